// File: rtl/cu_pkg.sv
// Shared opcode, ALU-select and state encodings for the control unit.
// Instruction classes are what cu_decode hands to the sequencer.
package cu_pkg;

    localparam int OPC_W   = 5;
    localparam int CTRL_W  = 5;
    localparam int STATE_W = 4;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    localparam logic [CTRL_W-1:0] ALU_ADD = 5'b00011;
    localparam logic [CTRL_W-1:0] ALU_SUB = 5'b00100;
    localparam logic [CTRL_W-1:0] ALU_AND = 5'b01000;
    localparam logic [CTRL_W-1:0] ALU_OR  = 5'b01001;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_R,
        CL_I,
        CL_LD,
        CL_ST,
        CL_HALT
    } cls_t;

    typedef enum logic [STATE_W-1:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } state_t;

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder: IR[31:27] -> instruction class and ALU select.
// Loads and stores use ALU_ADD for base+offset address generation.
module cu_decode
    import cu_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode,
    output cls_t              cls,
    output logic [CTRL_W-1:0] alu_sel
);

    always_comb begin
        cls     = CL_NOP;
        alu_sel = '0;
        unique case (1'b1)
            (opcode == OP_ADD):  begin cls = CL_R;    alu_sel = ALU_ADD; end
            (opcode == OP_SUB):  begin cls = CL_R;    alu_sel = ALU_SUB; end
            (opcode == OP_AND):  begin cls = CL_R;    alu_sel = ALU_AND; end
            (opcode == OP_OR):   begin cls = CL_R;    alu_sel = ALU_OR;  end
            (opcode == OP_ADDI): begin cls = CL_I;    alu_sel = ALU_ADD; end
            (opcode == OP_ANDI): begin cls = CL_I;    alu_sel = ALU_AND; end
            (opcode == OP_ORI):  begin cls = CL_I;    alu_sel = ALU_OR;  end
            (opcode == OP_LD):   begin cls = CL_LD;   alu_sel = ALU_ADD; end
            (opcode == OP_ST):   begin cls = CL_ST;   alu_sel = ALU_ADD; end
            (opcode == OP_HALT): begin cls = CL_HALT; end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer driving the Datapath strobes, one state per clock.
// Define CU_MEM_WAIT_EN to stretch memory states until Mem_Ready.
module control_unit
    import cu_pkg::*;
(
    input  logic               Clock,
    input  logic               Clear,
    input  logic [31:0]        IR,
    input  logic               Stop,
`ifdef CU_MEM_WAIT_EN
    input  logic               Mem_Ready,
`endif
    output logic [CTRL_W-1:0]  CONTROL,
    output logic               IncPC,
    output logic               Read,
    output logic               Write,
    output logic               PC_Out,
    output logic               MDR_Out,
    output logic               ZLO_Out,
    output logic               C_Out,
    output logic               BA_Out,
    output logic               R_Out,
    output logic               PC_In,
    output logic               MDR_In,
    output logic               MAR_In,
    output logic               IR_In,
    output logic               Y_In,
    output logic               ZLO_In,
    output logic               R_In,
    output logic               G_RA,
    output logic               G_RB,
    output logic               G_RC,
    output logic               Run,
    output logic [STATE_W-1:0] State
);

    state_t            state_q;
    state_t            state_d;
    cls_t              cls;
    logic [CTRL_W-1:0] alu_sel;
    logic              mem_rdy;
    logic              unused_ir;

`ifdef CU_MEM_WAIT_EN
    assign mem_rdy = Mem_Ready;
`else
    assign mem_rdy = 1'b1;
`endif

    assign unused_ir = ^IR[26:0];
    assign State     = state_q;

    cu_decode u_decode (
        .opcode  (IR[31:27]),
        .cls     (cls),
        .alu_sel (alu_sel)
    );

    always_ff @(posedge Clock) begin
        if (!Clear) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        CONTROL = '0;
        {IncPC, Read, Write}                             = '0;
        {PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out, R_Out} = '0;
        {PC_In, MDR_In, MAR_In, IR_In, Y_In}             = '0;
        {ZLO_In, R_In, G_RA, G_RB, G_RC}                 = '0;
        Run = 1'b1;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                PC_Out  = 1'b1;
                MAR_In  = 1'b1;
                IncPC   = 1'b1;
                state_d = Stop ? S_HALT : S_T1;
            end
            S_T1: begin
                Read   = 1'b1;
                MDR_In = 1'b1;
                if (mem_rdy) state_d = S_T2;
            end
            S_T2: begin
                MDR_Out = 1'b1;
                IR_In   = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                unique case (cls)
                    CL_R: begin
                        {G_RB, R_Out, Y_In} = '1;
                        state_d = S_T4;
                    end
                    CL_I, CL_LD, CL_ST: begin
                        {G_RB, BA_Out, Y_In} = '1;
                        state_d = S_T4;
                    end
                    CL_HALT: state_d = S_HALT;
                    default: state_d = S_T0;
                endcase
            end
            S_T4: begin
                CONTROL = alu_sel;
                ZLO_In  = 1'b1;
                state_d = S_T5;
                if (cls == CL_R) {G_RC, R_Out} = '1;
                else             C_Out = 1'b1;
            end
            // Memory classes reuse T5 to load the effective address.
            S_T5: begin
                ZLO_Out = 1'b1;
                state_d = S_T0;
                if (cls == CL_LD || cls == CL_ST) begin
                    MAR_In  = 1'b1;
                    state_d = S_T6;
                end else begin
                    {G_RA, R_In} = '1;
                end
            end
            S_T6: begin
                state_d = S_T7;
                if (cls == CL_ST) begin
                    {G_RA, R_Out, MDR_In} = '1;
                end else begin
                    {Read, MDR_In} = '1;
                    if (!mem_rdy) state_d = S_T6;
                end
            end
            S_T7: begin
                state_d = S_T0;
                if (cls == CL_ST) begin
                    Write = 1'b1;
                    if (!mem_rdy) state_d = S_T7;
                end else begin
                    {MDR_Out, G_RA, R_In} = '1;
                end
            end
            S_HALT: Run = 1'b0;
            default: state_d = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit against a table-driven reference model.
// Also covers the CU_MEM_WAIT_EN build when that macro is defined.
module tb_control_unit;
    import cu_pkg::*;

    logic        Clock;
    logic        Clear;
    logic [31:0] IR;
    logic        Stop;
`ifdef CU_MEM_WAIT_EN
    logic        Mem_Ready;
`endif
    logic [4:0]  CONTROL;
    logic IncPC, Read, Write, PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out;
    logic R_Out, PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In;
    logic G_RA, G_RB, G_RC, Run;
    logic [3:0]  State;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop),
`ifdef CU_MEM_WAIT_EN
        .Mem_Ready(Mem_Ready),
`endif
        .CONTROL(CONTROL), .IncPC(IncPC), .Read(Read), .Write(Write),
        .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out),
        .C_Out(C_Out), .BA_Out(BA_Out), .R_Out(R_Out), .PC_In(PC_In),
        .MDR_In(MDR_In), .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In),
        .ZLO_In(ZLO_In), .R_In(R_In), .G_RA(G_RA), .G_RB(G_RB),
        .G_RC(G_RC), .Run(Run), .State(State)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [18:0] M_INCPC  = 19'd1 << 0;
    localparam logic [18:0] M_READ   = 19'd1 << 1;
    localparam logic [18:0] M_WRITE  = 19'd1 << 2;
    localparam logic [18:0] M_PCOUT  = 19'd1 << 3;
    localparam logic [18:0] M_MDROUT = 19'd1 << 4;
    localparam logic [18:0] M_ZLOOUT = 19'd1 << 5;
    localparam logic [18:0] M_COUT   = 19'd1 << 6;
    localparam logic [18:0] M_BAOUT  = 19'd1 << 7;
    localparam logic [18:0] M_ROUT   = 19'd1 << 8;
    localparam logic [18:0] M_PCIN   = 19'd1 << 9;
    localparam logic [18:0] M_MDRIN  = 19'd1 << 10;
    localparam logic [18:0] M_MARIN  = 19'd1 << 11;
    localparam logic [18:0] M_IRIN   = 19'd1 << 12;
    localparam logic [18:0] M_YIN    = 19'd1 << 13;
    localparam logic [18:0] M_ZLOIN  = 19'd1 << 14;
    localparam logic [18:0] M_RIN    = 19'd1 << 15;
    localparam logic [18:0] M_GRA    = 19'd1 << 16;
    localparam logic [18:0] M_GRB    = 19'd1 << 17;
    localparam logic [18:0] M_GRC    = 19'd1 << 18;

    localparam int C_NOP = 0, C_R = 1, C_I = 2;
    localparam int C_LD = 3, C_ST = 4, C_HALT = 5;

    typedef struct packed {
        logic [18:0] mask;
        logic [4:0]  ctrl;
        logic        run;
        logic [3:0]  st;
    } obs_t;

    logic [18:0] seq [0:5][0:7];
    logic [3:0]  st_seq [0:7];
    obs_t        obs_log [0:39];
    obs_t        exp_o;
    bit          exp_valid;
    int          tests;
    int          fails;

    function automatic obs_t sample();
        obs_t o;
        o.mask = {G_RC, G_RB, G_RA, R_In, ZLO_In, Y_In, IR_In, MAR_In,
                  MDR_In, PC_In, R_Out, BA_Out, C_Out, ZLO_Out, MDR_Out,
                  PC_Out, Write, Read, IncPC};
        o.ctrl = CONTROL;
        o.run  = Run;
        o.st   = State;
        return o;
    endfunction

    function automatic int cls_of(input logic [4:0] op);
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_OR)
            return C_R;
        if (op == OP_ADDI || op == OP_ANDI || op == OP_ORI) return C_I;
        if (op == OP_LD)   return C_LD;
        if (op == OP_ST)   return C_ST;
        if (op == OP_HALT) return C_HALT;
        return C_NOP;
    endfunction

    function automatic logic [4:0] alu_of(input logic [4:0] op);
        if (op == OP_ADD || op == OP_ADDI) return ALU_ADD;
        if (op == OP_LD || op == OP_ST)    return ALU_ADD;
        if (op == OP_SUB)                  return ALU_SUB;
        if (op == OP_AND || op == OP_ANDI) return ALU_AND;
        if (op == OP_OR || op == OP_ORI)   return ALU_OR;
        return 5'd0;
    endfunction

    function automatic int len_of(input int cl);
        if (cl == C_R || cl == C_I)   return 6;
        if (cl == C_LD || cl == C_ST) return 8;
        return 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, expv, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (exp_valid) begin
            obs_t a;
            a = sample();
            chk("strobes", 32'(a.mask), 32'(exp_o.mask));
            chk("control", 32'(a.ctrl), 32'(exp_o.ctrl));
            chk("run", 32'(a.run), 32'(exp_o.run));
            chk("state", 32'(a.st), 32'(exp_o.st));
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_exp(input logic [18:0] m, input logic [4:0] c,
                           input logic r, input logic [3:0] s);
        exp_o.mask = m;
        exp_o.ctrl = c;
        exp_o.run  = r;
        exp_o.st   = s;
        exp_valid  = 1'b1;
    endtask

    task automatic init_tables();
        for (int c = 0; c < 6; c++)
            for (int k = 0; k < 8; k++) seq[c][k] = '0;
        for (int c = 0; c < 6; c++) begin
            seq[c][0] = M_PCOUT | M_MARIN | M_INCPC;
            seq[c][1] = M_READ | M_MDRIN;
            seq[c][2] = M_MDROUT | M_IRIN;
        end
        seq[C_R][3] = M_GRB | M_ROUT | M_YIN;
        seq[C_R][4] = M_GRC | M_ROUT | M_ZLOIN;
        seq[C_R][5] = M_ZLOOUT | M_GRA | M_RIN;
        for (int c = C_I; c <= C_ST; c++) begin
            seq[c][3] = M_GRB | M_BAOUT | M_YIN;
            seq[c][4] = M_COUT | M_ZLOIN;
            seq[c][5] = M_ZLOOUT | M_MARIN;
        end
        seq[C_I][5]  = M_ZLOOUT | M_GRA | M_RIN;
        seq[C_LD][6] = M_READ | M_MDRIN;
        seq[C_LD][7] = M_MDROUT | M_GRA | M_RIN;
        seq[C_ST][6] = M_GRA | M_ROUT | M_MDRIN;
        seq[C_ST][7] = M_WRITE;
        st_seq = '{S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7};
    endtask

    task automatic do_reset();
        Clear = 1'b0;
        Stop  = 1'b0;
        tick();
        set_exp('0, '0, 1'b1, S_RESET);
        tick();
        set_exp('0, '0, 1'b1, S_RESET);
        Clear = 1'b1;
        tick();
    endtask

    task automatic halt_seq();
        for (int i = 0; i < 20; i++) begin
            set_exp('0, '0, 1'b0, S_HALT);
            Stop = 1'($urandom_range(0, 1));
            tick();
        end
        chk("halt_quiet", 32'({Run, sample().mask}), 32'd0);
        do_reset();
    endtask

    task automatic abort_seq();
        chk("abort_strobes", 32'(sample().mask), 32'd0);
        chk("abort_state", 32'(State), 32'(S_RESET));
        Stop = 1'b0;
        set_exp('0, '0, 1'b1, S_RESET);
        tick();
        set_exp('0, '0, 1'b1, S_RESET);
        Clear = 1'b1;
        tick();
    endtask

    task automatic run_instr(input logic [4:0] opc, input bit stop_t0,
                             input bit stop_mid, input int abort_k);
        logic [31:0] r;
        int cl, n, w;
        r  = $urandom();
        IR = {opc, r[26:0]};
        cl = cls_of(opc);
        n  = len_of(cl);
        for (int k = 0; k < n; k++) begin
            w = 0;
`ifdef CU_MEM_WAIT_EN
            if (k == 1 || (cl == C_LD && k == 6) || (cl == C_ST && k == 7))
                w = $urandom_range(0, 2);
`endif
            for (int j = 0; j <= w; j++) begin
                set_exp(seq[cl][k], (k == 4) ? alu_of(opc) : 5'd0,
                        1'b1, st_seq[k]);
                if (k == 0) Stop = stop_t0;
                else Stop = stop_mid ? 1'b1 : 1'($urandom_range(0, 1));
`ifdef CU_MEM_WAIT_EN
                Mem_Ready = (j == w);
`endif
                if (k == abort_k) Clear = 1'b0;
                tick();
                if (k == abort_k) begin
                    abort_seq();
                    return;
                end
            end
            if (k == 0 && stop_t0) begin
                halt_seq();
                return;
            end
        end
        Stop = 1'b0;
        if (cl == C_HALT) halt_seq();
    endtask

    task automatic measure(input logic [31:0] ir, input int t1_wait,
                           output int lat);
        exp_valid = 1'b0;
        Stop = 1'b0;
        IR   = ir;
        lat  = 40;
        for (int c = 0; c < 40; c++) begin
            obs_log[c] = sample();
`ifdef CU_MEM_WAIT_EN
            Mem_Ready = !(c >= 1 && c <= t1_wait);
`else
            if (t1_wait < 0) Stop = 1'b0;
`endif
            tick();
            if (State == S_T0) begin
                lat = c + 1;
                break;
            end
        end
`ifdef CU_MEM_WAIT_EN
        Mem_Ready = 1'b1;
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, cnt, abort_k;
        logic [4:0] ops [0:11];
        tests = 0;
        fails = 0;
        exp_valid = 1'b0;
        init_tables();
        Clear = 1'b0;
        Stop  = 1'b0;
        IR    = '0;
`ifdef CU_MEM_WAIT_EN
        Mem_Ready = 1'b1;
`endif
        tick();
        set_exp('0, '0, 1'b1, S_RESET);
        tick();
        set_exp('0, '0, 1'b1, S_RESET);
        chk("reset_state", 32'(State), 32'd0);
        chk("reset_run", 32'(Run), 32'd1);
        Clear = 1'b1;
        tick();

        measure(32'h6908001A, 0, lat);
        chk("ori_latency", lat, 6);
        chk("ori_t4_ctrl", 32'(obs_log[4].ctrl), 32'h09);
        chk("ori_t4_strb", 32'(obs_log[4].mask), 32'(M_COUT | M_ZLOIN));
        chk("ori_t5_strb", 32'(obs_log[5].mask),
            32'(M_ZLOOUT | M_GRA | M_RIN));
        chk("ori_t0_ctrl", 32'(obs_log[0].ctrl), 32'd0);

        measure({OP_ADD, 27'h0123456}, 0, lat);
        chk("add_latency", lat, 6);
        chk("add_t3_strb", 32'(obs_log[3].mask),
            32'(M_GRB | M_ROUT | M_YIN));
        chk("add_t4_ctrl", 32'(obs_log[4].ctrl), 32'(ALU_ADD));
        chk("add_t4_strb", 32'(obs_log[4].mask),
            32'(M_GRC | M_ROUT | M_ZLOIN));

        measure({OP_LD, 27'h0000040}, 0, lat);
        chk("ld_latency", lat, 8);
        chk("ld_t1_read", 32'(obs_log[1].mask), 32'(M_READ | M_MDRIN));
        chk("ld_t6_read", 32'(obs_log[6].mask), 32'(M_READ | M_MDRIN));
        measure({OP_ST, 27'h0000080}, 0, lat);
        chk("st_latency", lat, 8);
        cnt = 0;
        for (int c = 0; c < 8; c++) cnt += int'(obs_log[c].mask[2]);
        chk("st_write_count", cnt, 1);
        chk("st_t7_write", 32'(obs_log[7].mask), 32'(M_WRITE));

        measure({5'b11111, 27'h0}, 0, lat);
        chk("nop_latency", lat, 4);
        chk("nop_t3_quiet", 32'(obs_log[3].mask), 32'd0);

`ifdef CU_MEM_WAIT_EN
        measure({OP_ADD, 27'h0}, 3, lat);
        chk("wait_latency", lat, 9);
        cnt = 0;
        for (int c = 0; c < 9; c++) cnt += int'(obs_log[c].mask[1]);
        chk("wait_read_count", cnt, 4);
        chk("wait_t2_state", 32'(obs_log[5].st), 32'(S_T2));
`endif

        run_instr(OP_ADD, 1'b0, 1'b1, -1);
        run_instr(OP_SUB, 1'b1, 1'b0, -1);
        run_instr(OP_LD, 1'b0, 1'b0, 5);
        run_instr(OP_ORI, 1'b0, 1'b0, -1);

        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI,
                OP_ORI, OP_LD, OP_ST, OP_HALT, 5'b10001, 5'b11111};
        for (int i = 0; i < 60; i++) begin
            logic [4:0] op;
            op = ops[$urandom_range(0, 11)];
            abort_k = ($urandom_range(0, 9) == 0)
                    ? int'($urandom_range(0, 7)) : -1;
            run_instr(op, ($urandom_range(0, 19) == 0), 1'b0, abort_k);
        end

        exp_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
